// File: rtl/route_selector.sv
// Route selector: picks one productive output port from the routing mask, requests it from the
// crossbar and holds it as a route lock until the tail leaves. ROUTE_RESELECT_EN enables re-pick on busy.
`ifndef PE
`define PE    0
`endif
`ifndef X_POS
`define X_POS 1
`endif
`ifndef Y_POS
`define Y_POS 2
`endif
`ifndef X_NEG
`define X_NEG 3
`endif
`ifndef Y_NEG
`define Y_NEG 4
`endif

module route_selector #(
    parameter int         PORT_DIR = `X_POS,
    parameter logic [1:0] RR_INIT  = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       head_valid_din,
    input  logic [3:0] valid_channels_din,
    input  logic [3:0] port_status_din,
    input  logic [3:0] grant_din,
    input  logic       tail_sent_din,
    output logic [3:0] request_dout,
    output logic       route_lock_dout,
    output logic       route_error_dout
);

    typedef enum logic [1:0] {IDLE, REQUEST, TRANSFER} state_t;

    state_t     state, state_nxt;
    logic [1:0] rr_ptr, rr_ptr_nxt;
    logic [3:0] mask_q, mask_nxt;
    logic [3:0] sel_q, sel_nxt;
    logic       err_q, err_nxt;
    logic [3:0] cand;

    // First set bit scanning from ptr upward, wrapping modulo 4; result is one-hot or zero.
    function automatic logic [3:0] rr_pick(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (m[idx]) rr_pick = 4'b0001 << idx;
        end
    endfunction

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        oh_idx = '0;
        for (int i = 0; i < 4; i++)
            if (oh[i]) oh_idx = 2'(i);
    endfunction

    assign cand = valid_channels_din & port_status_din;

`ifdef ROUTE_RESELECT_EN
    logic [3:0] alt;
    assign alt = mask_q & port_status_din & ~sel_q;
`endif

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        mask_nxt   = mask_q;
        sel_nxt    = sel_q;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (head_valid_din) begin
                    if (valid_channels_din == 4'b0000) begin
                        err_nxt = 1'b1;
                    end else begin
                        // Prefer free ports; fall back to any productive port when all are busy.
                        sel_nxt   = rr_pick((cand != 4'b0000) ? cand : valid_channels_din, rr_ptr);
                        mask_nxt  = valid_channels_din;
                        state_nxt = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if ((grant_din & sel_q) != 4'b0000) begin
                    state_nxt  = TRANSFER;
                    rr_ptr_nxt = oh_idx(sel_q) + 2'd1;
                end
`ifdef ROUTE_RESELECT_EN
                else if ((port_status_din & sel_q) == 4'b0000 && alt != 4'b0000) begin
                    sel_nxt = rr_pick(alt, rr_ptr);
                end
`endif
            end
            TRANSFER: begin
                if (tail_sent_din) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= RR_INIT;
            mask_q <= '0;
            sel_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            mask_q <= mask_nxt;
            sel_q  <= sel_nxt;
            err_q  <= err_nxt;
        end
    end

    // Outputs decode registered state only, so reset clears them without waiting for a clock.
    assign request_dout     = (state == IDLE) ? 4'b0000 : sel_q;
    assign route_lock_dout  = (state == TRANSFER);
    assign route_error_dout = err_q;

    a_req_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(request_dout))
        else $error("route_selector[%0d]: request not one-hot", PORT_DIR);
    a_sel_in_mask: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) || ((sel_q & ~mask_q) == 4'b0000))
        else $error("route_selector[%0d]: selection outside latched mask", PORT_DIR);

endmodule

// File: tb/tb_route_selector.sv
// Scoreboarded bench for route_selector: directed scenarios then random traffic against a packet-level model.
module tb_route_selector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       head_valid_din = 1'b0;
    logic [3:0] valid_channels_din = '0;
    logic [3:0] port_status_din = '0;
    logic [3:0] grant_din = '0;
    logic       tail_sent_din = 1'b0;
    logic [3:0] request_dout;
    logic       route_lock_dout;
    logic       route_error_dout;

    route_selector #(.RR_INIT(2'd0)) dut (
        .clk(clk), .reset(reset),
        .head_valid_din(head_valid_din), .valid_channels_din(valid_channels_din),
        .port_status_din(port_status_din), .grant_din(grant_din), .tail_sent_din(tail_sent_din),
        .request_dout(request_dout), .route_lock_dout(route_lock_dout),
        .route_error_dout(route_error_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic       lock;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Packet-level model: which port the current packet owns, whether the crossbar granted it.
    bit         m_busy, m_granted, m_err;
    int         m_sel, m_ptr;
    logic [3:0] m_mask;

    function automatic int pick(input logic [3:0] pool, input int ptr);
        for (int k = 0; k < 4; k++)
            if (pool[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_granted = 0; m_err = 0; m_sel = 0; m_ptr = 0; m_mask = '0;
    endtask

    task automatic model_step(input bit hv, input logic [3:0] vc, input logic [3:0] ps,
                              input logic [3:0] gr, input bit ts);
        logic [3:0] pool, alt;
        if (!m_busy) begin
            if (hv) begin
                if (vc == 4'b0000) m_err = 1;
                else begin
                    pool   = ((vc & ps) != 4'b0000) ? (vc & ps) : vc;
                    m_sel  = pick(pool, m_ptr);
                    m_mask = vc;
                    m_busy = 1;
                end
            end
        end else if (!m_granted) begin
            if (gr[m_sel]) begin
                m_granted = 1;
                m_ptr = (m_sel + 1) % 4;
            end else begin
                alt = m_mask & ps;
                alt[m_sel] = 1'b0;
`ifdef ROUTE_RESELECT_EN
                if (!ps[m_sel] && alt != 4'b0000) m_sel = pick(alt, m_ptr);
`endif
            end
        end else if (ts) begin
            m_busy = 0;
            m_granted = 0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req = '0;
        if (m_busy) e.req[m_sel] = 1'b1;
        e.lock = m_granted;
        e.err  = m_err;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next rising edge.
    task automatic step(input bit hv, input logic [3:0] vc, input logic [3:0] ps,
                        input logic [3:0] gr, input bit ts);
        @(negedge clk);
        head_valid_din = hv; valid_channels_din = vc; port_status_din = ps;
        grant_din = gr; tail_sent_din = ts;
        model_step(hv, vc, ps, gr, ts);
        exp_q.push_back(model_out());
    endtask

    function automatic logic [3:0] cur_grant();
        logic [3:0] g;
        g = '0;
        g[m_sel] = 1'b1;
        return g;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 4'b0000, 4'b1111, 4'b0000, 0);
    endtask

    // Reset asserted between edges: outputs must fall before the next rising edge.
    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        head_valid_din = 0; valid_channels_din = '0; port_status_din = '0;
        grant_din = '0; tail_sent_din = 0;
        #1 reset = 1'b1;
        #1;
        tests++;
        if (request_dout !== 4'b0000 || route_lock_dout !== 1'b0 || route_error_dout !== 1'b0) begin
            fails++;
            $display("FAIL async_reset t=%0t req=%b lock=%b err=%b, required 0000/0/0",
                     $time, request_dout, route_lock_dout, route_error_dout);
        end
        model_reset();
        z = '0;
        exp_q.push_back(z);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (request_dout !== e.req || route_lock_dout !== e.lock || route_error_dout !== e.err) begin
                fails++;
                $display("FAIL cycle_check t=%0t req=%b lock=%b err=%b, required req=%b lock=%b err=%b",
                         $time, request_dout, route_lock_dout, route_error_dout, e.req, e.lock, e.err);
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        tests++;
        if (request_dout !== 4'b0000 || route_lock_dout !== 1'b0 || route_error_dout !== 1'b0) begin
            fails++;
            $display("FAIL reset_state req=%b lock=%b err=%b, required 0000/0/0",
                     request_dout, route_lock_dout, route_error_dout);
        end
        reset = 1'b0;

        // Basic selection, grant, release; then round-robin on the same mask.
        step(1, 4'b0110, 4'b1111, 4'b0000, 0);
        step(0, 4'b0000, 4'b1111, 4'b0010, 0);
        step(0, 4'b0000, 4'b1111, 4'b0000, 1);
        step(1, 4'b0110, 4'b1111, 4'b0000, 0);
        step(0, 4'b0000, 4'b1111, cur_grant(), 0);
        step(0, 4'b0000, 4'b1111, 4'b0000, 1);
        step(1, 4'b0110, 4'b1111, 4'b0000, 0);
        step(0, 4'b0000, 4'b1111, cur_grant(), 0);
        step(0, 4'b0000, 4'b1111, 4'b0000, 1);
        idle_cycles(1);

        // Status preference, then all-busy fallback held without a grant.
        do_reset();
        step(1, 4'b1010, 4'b0010, 4'b0000, 0);
        step(0, 4'b0000, 4'b0010, cur_grant(), 0);
        step(0, 4'b0000, 4'b0010, 4'b0000, 1);
        do_reset();
        step(1, 4'b1010, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, cur_grant(), 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 1);

        // Empty mask sets a sticky error; stray grant is ignored in REQUEST.
        step(1, 4'b0000, 4'b1111, 4'b0000, 0);
        idle_cycles(2);
        do_reset();
        step(1, 4'b0001, 4'b1111, 4'b0000, 0);
        step(0, 4'b0000, 4'b1111, 4'b0100, 1);
        step(0, 4'b0000, 4'b1111, 4'b0001, 0);

        // Reset abandons a lock mid-transfer; then a single-flit packet.
        do_reset();
        step(1, 4'b1000, 4'b1111, 4'b0000, 0);
        step(0, 4'b0000, 4'b1111, 4'b1000, 0);
        step(0, 4'b0000, 4'b1111, 4'b0000, 1);
        step(0, 4'b0000, 4'b1111, 4'b0000, 0);

        // Chosen port goes busy without a grant.
        do_reset();
        step(1, 4'b0101, 4'b1111, 4'b0000, 0);
        step(0, 4'b0000, 4'b0100, 4'b0000, 0);
        step(0, 4'b0000, 4'b0100, 4'b0000, 0);
        step(0, 4'b0000, 4'b0100, cur_grant(), 0);
        step(0, 4'b0000, 4'b0100, 4'b0000, 1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] vc, gr;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                vc = ($urandom_range(0, 31) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                gr = '0;
                if ($urandom_range(0, 2) == 0) gr[$urandom_range(0, 3)] = 1'b1;
                step($urandom_range(0, 3) != 0, vc, 4'($urandom_range(0, 15)), gr,
                     $urandom_range(0, 3) == 0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
